// File: rtl/can_tx_stuffer.sv
// can_tx_stuffer: serialises a word as SOF + data + CRC-15 + delimiter with CAN bit stuffing,
// advancing one bus bit per bit_tick.
module can_tx_stuffer #(
    parameter int          NBITS     = 32,
    parameter logic [14:0] CRC_POLY  = 15'h4599,
    parameter int          STUFF_RUN = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] data_in,
    input  logic             bit_tick,
    output logic             tx_bit,
    output logic             busy,
    output logic             done,
    output logic [14:0]      crc_out,
    output logic [5:0]       stuff_cnt
);
    localparam int CW = $clog2(NBITS + 15);
    localparam int RW = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {IDLE, SOF, DATA, CRC, DELIM} state_t;

    state_t           state_q;
    logic [NBITS-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic [14:0]      crc_q, crc_out_q, crc_d;
    logic [RW-1:0]    run_q;
    logic [5:0]       stuff_q;
    logic             last_q, tx_q, busy_q, done_q;
    logic             nbit, stuff_now;

    // nbit is the next frame bit; a pending stuff bit pre-empts it without consuming it
    always_comb begin
        nbit      = state_q == DATA ? data_q[NBITS-1] : state_q == CRC ? crc_q[14] : state_q != SOF;
        stuff_now = run_q == RW'(STUFF_RUN) && (state_q == DATA || state_q == CRC || state_q == DELIM);
        crc_d     = {crc_q[13:0], 1'b0} ^ ((nbit ^ crc_q[14]) ? CRC_POLY : 15'h0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            crc_out_q <= '0;
            run_q     <= '0;
            stuff_q   <= '0;
            last_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && !busy_q) begin
                    data_q    <= data_in;
                    crc_q     <= '0;
                    crc_out_q <= '0;
                    stuff_q   <= '0;
                    run_q     <= '0;
                    last_q    <= 1'b0;
                    busy_q    <= 1'b1;
                    state_q   <= SOF;
                end
            end else if (bit_tick) begin
                if (stuff_now) begin
                    tx_q    <= ~last_q;
                    last_q  <= ~last_q;
                    run_q   <= RW'(1);
                    stuff_q <= stuff_q + 6'd1;
                end else begin
                    tx_q   <= nbit;
                    last_q <= nbit;
                    run_q  <= (state_q != SOF && nbit == last_q) ? run_q + RW'(1) : RW'(1);
                    case (state_q)
                        SOF: begin
                            crc_q   <= crc_d;
                            cnt_q   <= CW'(NBITS - 1);
                            state_q <= DATA;
                        end
                        DATA: begin
                            crc_q  <= crc_d;
                            data_q <= data_q << 1;
                            if (cnt_q == '0) begin
                                crc_out_q <= crc_d;
                                cnt_q     <= CW'(14);
                                state_q   <= CRC;
                            end else begin
                                cnt_q <= cnt_q - CW'(1);
                            end
                        end
                        CRC: begin
                            crc_q   <= {crc_q[13:0], 1'b0};
                            cnt_q   <= cnt_q - CW'(1);
                            state_q <= cnt_q == '0 ? DELIM : CRC;
                        end
                        DELIM: begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tx_bit    = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign crc_out   = crc_out_q;
    assign stuff_cnt = stuff_q;
endmodule
